stage4_message_capture: RTL
===========================

Name: stage4_message_capture

Overview:
- Upstream neighbour of the SS5 field-extraction stage.
- Takes the framed word stream from the feed parser, assembles up to three complete messages into lane buffers, and decodes each message type byte into a mux-control code.
- Presents the batch (message_en, message_1..3, message_mux_control_m1..m3) to the downstream combinational field extractors and holds it until they acknowledge.

Parameters:
- MAX_MESSAGE_BITS, 512, lane buffer width; must be a multiple of WORD_BITS.
- WORD_BITS, 64, input word width.
- MUX_W, 2, width of message_mux_control codes.
- FLUSH_CYCLES, 16, idle cycles after which a partial batch is emitted.

Ports:
- clk  in  1  single clock; all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_sop  in  1  first word of a message.
- in_eop  in  1  last word of a message.
- in_data  in  WORD_BITS  message word; first byte of a message is in_data[WORD_BITS-1:WORD_BITS-8].
- in_ready  out  1  capture accepts a word when in_valid&in_ready.
- message_en  out  1  batch valid; held until message_ack.
- message_ack  in  1  downstream consumed the batch.
- message_1, message_2, message_3  out  MAX_MESSAGE_BITS  lane buffers, MSB-first packing.
- message_mux_control_m1, _m2, _m3  out  MUX_W  type codes per lane.
- overflow_err  out  1  one-cycle pulse, message longer than the buffer.
- frame_err  out  1  one-cycle pulse, sop inside a message or eop/data outside one.

Behaviour:
- Reset (async, rst=1): state IDLE; lane index 0; word index 0; flush counter 0. Outputs: message_en=0, in_ready=0 while rst is high and 1 after release; all message_* = 0; mux controls = NONE (0); error pulses 0.
- Type codes (shared constants): NONE=0, A=1 for byte 0x41, D=2 for 0x44, K=3 for 0x4B. Any other type byte gives NONE, but the message is still stored.
- FSM states: IDLE (no lane filled), FILL (≥1 lane filled or a message in progress), HOLD (batch presented).
- Accepted sop word:
  - Written to bits [MAX-1:MAX-WORD_BITS] of the current lane.
  - Lane's mux control latched from the type byte; word index set to 1.
  - State goes to FILL.
- Subsequent accepted words: word w goes to bits [MAX-1-w*WORD_BITS -: WORD_BITS].
  - When w reaches MAX/WORD_BITS, further words up to eop are dropped.
  - overflow_err pulses once per message; the message is kept, truncated.
- Accepted eop: lane closes and the lane index increments.
  - If the closed lane was lane 3 (index 2): next cycle state=HOLD, message_en=1, in_ready=0.
  - sop&eop in the same word is a one-word message.
- Frame errors:
  - sop while a message is open: frame_err pulse, the open lane is cleared and restarted with the new message (lane index unchanged).
  - Non-sop word with no open message: dropped, frame_err pulse.
- Flush:
  - In FILL, with no message open and no accepted word, the counter increments each cycle.
  - At FLUSH_CYCLES-1: enter HOLD and present the batch; unfilled lanes stay 0 with NONE.
  - Any accepted word clears the counter.
  - A message open when the counter would expire: no flush; the counter is frozen at 0.
- HOLD: outputs stable; in_ready=0.
  - message_ack=1: next cycle message_en=0, all lanes cleared to 0/NONE, lane index 0, state IDLE, in_ready=1.
  - message_ack outside HOLD is ignored.
- Latency: eop of third message accepted at cycle N gives message_en=1 at N+1. Ack at cycle M gives in_ready=1 at M+1.
- Reset mid-batch or mid-message: everything discarded, no error pulses.
- Outputs are registered; no combinational path from in_* to message_*.

Decomposition:
- Shared package/include: type codes NONE/A/D/K, type byte constants 0x41/0x44/0x4B, MUX_W, MAX_MESSAGE_BITS. Same defines consumed by the downstream field-extraction stages.
- One natural sub-module: stage4_lane_buffer (one instance per lane).
  - Holds the word-indexed write, truncation/overflow detect, type decode and clear.
  - The top-level keeps the FSM, lane index, flush counter and handshake.

Test Plan:
- Three 2-word messages with types 0x41, 0x44, 0x4B, back-to-back -> message_en=1 one cycle after third eop; controls 1,2,3; lane contents MSB-aligned, low bits 0; in_ready=0 until ack; ack clears lanes to 0.
- One 1-word message type 0x44, then 16 idle cycles -> message_en asserts after FLUSH_CYCLES; m1=2, m2=m3=0, message_2=message_3=0.
- A 10-word message, default 512/64 -> words 9-10 dropped; overflow_err single pulse; message_1 holds words 1-8.
- sop, data, sop (new type 0x4B), eop -> frame_err pulse; lane 1 holds only the second message; m1=3.
- Stray non-sop word while idle -> frame_err pulse; state and lanes unchanged.
- rst asserted mid-HOLD (asynchronous, between edges) -> message_en and all lanes/controls 0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/stage4_message_capture_pkg.sv
// Shared constants and types for stage-4 message capture and the downstream field extractors.
package stage4_message_capture_pkg;

    localparam int unsigned MAX_MESSAGE_BITS = 512;
    localparam int unsigned WORD_BITS        = 64;
    localparam int unsigned MUX_W            = 2;
    localparam int unsigned FLUSH_CYCLES     = 16;

    localparam int unsigned LANE_WORDS = MAX_MESSAGE_BITS / WORD_BITS;
    localparam int unsigned NUM_LANES  = 3;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned WORD_IDX_W = $clog2(LANE_WORDS + 1);
    localparam int unsigned FLUSH_W    = $clog2(FLUSH_CYCLES);

    localparam logic [7:0] TYPE_BYTE_A = 8'h41;
    localparam logic [7:0] TYPE_BYTE_D = 8'h44;
    localparam logic [7:0] TYPE_BYTE_K = 8'h4B;

    typedef enum logic [MUX_W-1:0] {
        MUX_NONE = 2'd0,
        MUX_A    = 2'd1,
        MUX_D    = 2'd2,
        MUX_K    = 2'd3
    } mux_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD
    } cap_state_e;

    // Unknown type bytes map to NONE; the message body is still kept.
    function automatic mux_code_e decode_type(input logic [7:0] type_byte);
        case (type_byte)
            TYPE_BYTE_A: return MUX_A;
            TYPE_BYTE_D: return MUX_D;
            TYPE_BYTE_K: return MUX_K;
            default:     return MUX_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stage4_lane_buffer.sv
// One message lane: word-indexed MSB-first write, truncation with overflow detect, type decode, clear.
module stage4_lane_buffer
    import stage4_message_capture_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        start,
    input  logic                        append,
    input  logic [WORD_BITS-1:0]        word,
    output logic [MAX_MESSAGE_BITS-1:0] data,
    output logic [MUX_W-1:0]            mux_control,
    output logic                        overflow_c
);

    logic [WORD_IDX_W-1:0] word_idx;
    logic                  overflow_seen;
    logic                  full_c;

    assign full_c     = (word_idx == WORD_IDX_W'(LANE_WORDS));
    assign overflow_c = append & full_c & ~overflow_seen;

    // A start always wipes the lane, so a restarted message never inherits stale words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data          <= '0;
            mux_control   <= MUX_NONE;
            word_idx      <= '0;
            overflow_seen <= 1'b0;
        end else if (clear) begin
            data          <= '0;
            mux_control   <= MUX_NONE;
            word_idx      <= '0;
            overflow_seen <= 1'b0;
        end else if (start) begin
            data          <= MAX_MESSAGE_BITS'(word) << (MAX_MESSAGE_BITS - WORD_BITS);
            mux_control   <= decode_type(word[WORD_BITS-1 -: 8]);
            word_idx      <= WORD_IDX_W'(1);
            overflow_seen <= 1'b0;
        end else if (append) begin
            if (!full_c) begin
                for (int unsigned k = 0; k < LANE_WORDS; k++) begin
                    if (word_idx == WORD_IDX_W'(k)) begin
                        data[MAX_MESSAGE_BITS-1-k*WORD_BITS -: WORD_BITS] <= word;
                    end
                end
                word_idx <= word_idx + WORD_IDX_W'(1);
            end else begin
                overflow_seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage4_message_capture.sv
// Assembles up to three framed messages into lane buffers and presents them as one held batch.
module stage4_message_capture
    import stage4_message_capture_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_sop,
    input  logic                        in_eop,
    input  logic [WORD_BITS-1:0]        in_data,
    output logic                        in_ready,
    output logic                        message_en,
    input  logic                        message_ack,
    output logic [MAX_MESSAGE_BITS-1:0] message_1,
    output logic [MAX_MESSAGE_BITS-1:0] message_2,
    output logic [MAX_MESSAGE_BITS-1:0] message_3,
    output logic [MUX_W-1:0]            message_mux_control_m1,
    output logic [MUX_W-1:0]            message_mux_control_m2,
    output logic [MUX_W-1:0]            message_mux_control_m3,
    output logic                        overflow_err,
    output logic                        frame_err
);

    cap_state_e             state;
    logic [LANE_IDX_W-1:0]  lane_idx;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic                   msg_open;

    logic                   accept_c;
    logic                   clear_c;
    logic                   close_c;
    logic                   frame_c;
    logic                   last_lane_c;
    logic [NUM_LANES-1:0]   start_c;
    logic [NUM_LANES-1:0]   append_c;
    logic [NUM_LANES-1:0]   lane_ovf_c;
    logic [MAX_MESSAGE_BITS-1:0] lane_data [NUM_LANES];
    logic [MUX_W-1:0]            lane_mux  [NUM_LANES];

    assign accept_c    = in_valid & in_ready;
    assign clear_c     = (state == ST_HOLD) & message_ack;
    assign close_c     = accept_c & in_eop & (in_sop | msg_open);
    assign frame_c     = accept_c & (in_sop ? msg_open : ~msg_open);
    assign last_lane_c = (lane_idx == LANE_IDX_W'(NUM_LANES - 1));

    // Route accepted words to the lane currently being filled.
    always_comb begin
        start_c  = '0;
        append_c = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            start_c[i]  = accept_c & in_sop & (lane_idx == LANE_IDX_W'(i));
            append_c[i] = accept_c & ~in_sop & msg_open & (lane_idx == LANE_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        stage4_lane_buffer u_lane (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear_c),
            .start       (start_c[g]),
            .append      (append_c[g]),
            .word        (in_data),
            .data        (lane_data[g]),
            .mux_control (lane_mux[g]),
            .overflow_c  (lane_ovf_c[g])
        );
    end

    assign message_1              = lane_data[0];
    assign message_2              = lane_data[1];
    assign message_3              = lane_data[2];
    assign message_mux_control_m1 = lane_mux[0];
    assign message_mux_control_m2 = lane_mux[1];
    assign message_mux_control_m3 = lane_mux[2];

    // Batch FSM: fill lanes, flush on idle, hold until the extractors acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            lane_idx     <= '0;
            flush_cnt    <= '0;
            msg_open     <= 1'b0;
            in_ready     <= 1'b0;
            message_en   <= 1'b0;
            frame_err    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            frame_err    <= frame_c;
            overflow_err <= |lane_ovf_c;
            if (state == ST_HOLD) begin
                in_ready <= 1'b0;
                if (message_ack) begin
                    state      <= ST_IDLE;
                    message_en <= 1'b0;
                    in_ready   <= 1'b1;
                    lane_idx   <= '0;
                end
            end else begin
                in_ready <= 1'b1;
                if (accept_c) begin
                    flush_cnt <= '0;
                    if (in_sop) begin
                        state <= ST_FILL;
                    end
                    if (close_c) begin
                        msg_open <= 1'b0;
                        if (last_lane_c) begin
                            state      <= ST_HOLD;
                            message_en <= 1'b1;
                            in_ready   <= 1'b0;
                        end else begin
                            lane_idx <= lane_idx + LANE_IDX_W'(1);
                        end
                    end else if (in_sop) begin
                        msg_open <= 1'b1;
                    end
                end else if ((state == ST_FILL) && !msg_open) begin
                    if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                        flush_cnt  <= '0;
                        state      <= ST_HOLD;
                        message_en <= 1'b1;
                        in_ready   <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end else begin
                    // An open message freezes the idle counter so it can never flush mid-message.
                    flush_cnt <= '0;
                end
            end
        end
    end

endmodule
